// File: rtl/mdio_pkg.sv
// MDIO master shared definitions: start codes, opcodes, frame field lengths, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mdio_pkg;

    // Start-of-frame codes
    localparam logic [1:0] ST_C22 = 2'b01;
    localparam logic [1:0] ST_C45 = 2'b00;

    // Opcodes
    localparam logic [1:0] OP_C22_WR   = 2'b01;
    localparam logic [1:0] OP_C22_RD   = 2'b10;
    localparam logic [1:0] OP_C45_ADDR = 2'b00;
    localparam logic [1:0] OP_C45_WR   = 2'b01;
    localparam logic [1:0] OP_C45_RD   = 2'b11;
    localparam logic [1:0] OP_C45_PRIA = 2'b10;

    // Frame field lengths in bits (after preamble)
    localparam int HDR_LEN  = 14;
    localparam int TA_LEN   = 2;
    localparam int DATA_LEN = 16;

    // Turnaround pattern driven by the master on write-type frames
    localparam logic [1:0] TA_DRIVE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_RESP
    } state_t;

    // Frames in which the PHY owns the line from TA onward
    function automatic logic is_read(input logic c45, input logic [1:0] op);
        if (c45) begin
            return (op == OP_C45_RD) || (op == OP_C45_PRIA);
        end
        return op == OP_C22_RD;
    endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC divider: mdc low for CLK_DIV cycles then high for CLK_DIV cycles, with window strobes.
// Latency: first window starts on the first cycle en is high after being low.
// Backpressure: none; free-running while en is high, cleared while en is low.
// Ports: clk/rst system clock and sync reset; en runs the divider; mdc is the management
// clock; win_start marks the first cycle of a bit window, win_end the last.
module mdio_mdc_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic mdc,
    output logic win_start,
    output logic win_end
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             mdc_q, mdc_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        mdc_d     = mdc_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            mdc_d     = ~mdc_q;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    // Held cleared while disabled so every frame starts on a fresh low half
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt_q <= '0;
            mdc_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            mdc_q     <= mdc_d;
        end
    end

    assign mdc       = mdc_q;
    assign win_start = en && (div_cnt_q == '0) && !mdc_q;
    assign win_end   = en && (div_cnt_q == DIV_LAST) && mdc_q;

endmodule

// File: rtl/mdio_master.sv
// MDIO Clause 22/45 management master: serialises one command, returns read data + error flag.
// Latency: rsp_valid at T+1+(PREAMBLE_LEN+32)*2*CLK_DIV after acceptance at T (T+1 if C45 unsupported).
// Backpressure: cmd_ready only in IDLE; response is a one-cycle pulse with no backpressure.
// Ports: cmd_* request (valid/ready), rsp_* completion, busy status, mdc/mdio_o/mdio_oe/mdio_i pad side.
module mdio_master #(
    parameter int CLK_DIV      = 50,
    parameter int PREAMBLE_LEN = 32,
    parameter int SUPPORT_C45  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_c45,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    import mdio_pkg::*;

    localparam logic [4:0] PRE_LAST  = 5'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
    localparam logic [4:0] HDR_LAST  = 5'(HDR_LEN - 1);
    localparam logic [4:0] TA_LAST   = 5'(TA_LEN - 1);
    localparam logic [4:0] DATA_LAST = 5'(DATA_LEN - 1);

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] tx_sr_q, tx_sr_d;      // ST,OP,PHY,REG,TA,DATA; MSB is the bit on the line
    logic        rd_q, rd_d;
    logic [15:0] rx_q, rx_d;
    logic        err_q, err_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        pad_o_q, pad_o_d;
    logic        pad_oe_q, pad_oe_d;

    logic        active;
    logic        bit_o, bit_oe;
    logic        win_start, win_end;

    assign active = (state_q == S_PRE) || (state_q == S_HDR) ||
                    (state_q == S_TA)  || (state_q == S_DATA);

    mdio_mdc_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_mdc_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (active),
        .mdc       (mdc),
        .win_start (win_start),
        .win_end   (win_end)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rd_d       = rd_q;
        rx_d       = rx_q;
        err_d      = err_q;
        rsp_data_d = rsp_data_q;
        bit_o      = 1'b1;
        bit_oe     = 1'b0;
        pad_o_d    = 1'b1;
        pad_oe_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    tx_sr_d   = {(cmd_c45 ? ST_C45 : ST_C22), cmd_op, cmd_phy, cmd_reg,
                                 TA_DRIVE, cmd_data};
                    rd_d      = is_read(cmd_c45, cmd_op);
                    err_d     = 1'b0;
                    bit_cnt_d = '0;
                    if (cmd_c45 && (SUPPORT_C45 == 0)) begin
                        // No frame on the wire; report the rejection straight away
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end else if (PREAMBLE_LEN == 0) begin
                        state_d = S_HDR;
                    end else begin
                        state_d = S_PRE;
                    end
                end
            end

            S_PRE: begin
                bit_o  = 1'b1;
                bit_oe = 1'b1;
                if (win_end) begin
                    if (bit_cnt_q == PRE_LAST) begin
                        state_d   = S_HDR;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end

            S_HDR: begin
                bit_o  = tx_sr_q[31];
                bit_oe = 1'b1;
                if (win_end) begin
                    tx_sr_d = {tx_sr_q[30:0], 1'b1};
                    if (bit_cnt_q == HDR_LAST) begin
                        state_d   = S_TA;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end

            S_TA: begin
                bit_o  = rd_q ? 1'b1 : tx_sr_q[31];
                bit_oe = !rd_q;
                if (win_end) begin
                    tx_sr_d = {tx_sr_q[30:0], 1'b1};
                    if (bit_cnt_q == TA_LAST) begin
                        // A responding PHY pulls the second TA bit low
                        if (rd_q) begin
                            err_d = mdio_i;
                        end
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end

            S_DATA: begin
                bit_o  = rd_q ? 1'b1 : tx_sr_q[31];
                bit_oe = !rd_q;
                if (win_end) begin
                    tx_sr_d = {tx_sr_q[30:0], 1'b1};
                    rx_d    = {rx_q[14:0], mdio_i};
                    if (bit_cnt_q == DATA_LAST) begin
                        if (rd_q) begin
                            rsp_data_d = {rx_q[14:0], mdio_i};
                        end
                        state_d   = S_RESP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end

            S_RESP: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pad drive is re-evaluated only on the first cycle of a window and held otherwise
        if (active) begin
            pad_o_d  = win_start ? bit_o  : pad_o_q;
            pad_oe_d = win_start ? bit_oe : pad_oe_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            tx_sr_q    <= '0;
            rd_q       <= 1'b0;
            rx_q       <= '0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
            pad_o_q    <= 1'b1;
            pad_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rd_q       <= rd_d;
            rx_q       <= rx_d;
            err_q      <= err_d;
            rsp_data_q <= rsp_data_d;
            pad_o_q    <= pad_o_d;
            pad_oe_q   <= pad_oe_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_valid && err_q;
    assign busy      = (state_q != S_IDLE);
    assign mdio_o    = pad_o_d;
    assign mdio_oe   = pad_oe_d;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: three instances (full preamble, no preamble, no C45 support).
// Latency: n/a.
// Backpressure: n/a.
module tb_mdio_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_c45;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_phy;
    logic [4:0]  cmd_reg;
    logic [15:0] cmd_data;
    logic        mdio_i;
    logic [1:0]  sel;

    logic [2:0]  rdy, rspv, rerr_v, bsy, mdcv, mo, moe;
    logic [15:0] rd0, rd1, rd2;

    logic        mon_rdy, mon_rspv, mon_err, mon_busy, mon_mdc, mon_o, mon_oe;
    logic [15:0] mon_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mdio_master #(.CLK_DIV(4), .PREAMBLE_LEN(32), .SUPPORT_C45(1)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && (sel == 2'd0)), .cmd_ready(rdy[0]),
        .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg),
        .cmd_data(cmd_data), .rsp_valid(rspv[0]), .rsp_data(rd0), .rsp_err(rerr_v[0]),
        .busy(bsy[0]), .mdc(mdcv[0]), .mdio_o(mo[0]), .mdio_oe(moe[0]), .mdio_i(mdio_i)
    );

    mdio_master #(.CLK_DIV(4), .PREAMBLE_LEN(0), .SUPPORT_C45(1)) u_np (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && (sel == 2'd1)), .cmd_ready(rdy[1]),
        .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg),
        .cmd_data(cmd_data), .rsp_valid(rspv[1]), .rsp_data(rd1), .rsp_err(rerr_v[1]),
        .busy(bsy[1]), .mdc(mdcv[1]), .mdio_o(mo[1]), .mdio_oe(moe[1]), .mdio_i(mdio_i)
    );

    mdio_master #(.CLK_DIV(4), .PREAMBLE_LEN(32), .SUPPORT_C45(0)) u_nc (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && (sel == 2'd2)), .cmd_ready(rdy[2]),
        .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg),
        .cmd_data(cmd_data), .rsp_valid(rspv[2]), .rsp_data(rd2), .rsp_err(rerr_v[2]),
        .busy(bsy[2]), .mdc(mdcv[2]), .mdio_o(mo[2]), .mdio_oe(moe[2]), .mdio_i(mdio_i)
    );

    // Observe whichever instance is under test
    always_comb begin
        mon_rdy = rdy[0]; mon_rspv = rspv[0]; mon_err = rerr_v[0]; mon_busy = bsy[0];
        mon_mdc = mdcv[0]; mon_o = mo[0]; mon_oe = moe[0]; mon_rd = rd0;
        if (sel == 2'd1) begin
            mon_rdy = rdy[1]; mon_rspv = rspv[1]; mon_err = rerr_v[1]; mon_busy = bsy[1];
            mon_mdc = mdcv[1]; mon_o = mo[1]; mon_oe = moe[1]; mon_rd = rd1;
        end else if (sel == 2'd2) begin
            mon_rdy = rdy[2]; mon_rspv = rspv[2]; mon_err = rerr_v[2]; mon_busy = bsy[2];
            mon_mdc = mdcv[2]; mon_o = mo[2]; mon_oe = moe[2]; mon_rd = rd2;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command, then record the line bit by bit (mid low-half of each window)
    // while playing PHY: phy_bits[63-k] is presented on mdio_i for window k.
    task automatic do_frame(input logic c45, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] rg, input logic [15:0] dat, input int nbits,
                            input logic [63:0] phy_bits, input logic hold,
                            output logic [63:0] tx, output logic [63:0] oe, output int lat,
                            output int waits, output logic [15:0] rdat, output logic rerr);
        int mdc_bad;
        int k;
        int ph;
        tx = '0; oe = '0; lat = -1; waits = 0; rdat = '0; rerr = 1'b0; mdc_bad = 0;
        @(negedge clk);
        cmd_c45 = c45; cmd_op = op; cmd_phy = phy; cmd_reg = rg; cmd_data = dat;
        cmd_valid = 1'b1;
        while (!mon_rdy && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!mon_rdy) begin
            chk("accept_timeout", mon_rdy, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        // Fields change while busy; the frame must still carry the latched values
        cmd_c45 = ~c45; cmd_op = ~op; cmd_phy = ~phy; cmd_reg = ~rg; cmd_data = ~dat;
        if (!hold) cmd_valid = 1'b0;
        chk("busy_t1", mon_busy, 1);
        chk("mdc_t1", mon_mdc, 0);
        for (int off = 1; off <= 1100; off++) begin
            if (off > 1) @(negedge clk);
            if (mon_rspv) begin
                lat  = off;
                rdat = mon_rd;
                rerr = mon_err;
                chk("mdc_resp", mon_mdc, 0);
                break;
            end
            k  = (off - 1) / 8;
            ph = (off - 1) % 8;
            if (k < nbits) begin
                if (ph == 0) mdio_i = phy_bits[63-k];
                if (ph == 2) begin
                    tx[63-k] = mon_o;
                    oe[63-k] = mon_oe;
                end
                if (mon_mdc != (ph >= 4)) mdc_bad++;
            end
        end
        mdio_i = 1'b1;
        chk("mdc_shape", mdc_bad, 0);
    endtask

    logic [63:0] tx, oe;
    logic [15:0] rd;
    logic        er;
    int          lat, w, cnt;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; sel = 2'd0; mdio_i = 1'b1;
        cmd_c45 = 1'b0; cmd_op = 2'b00; cmd_phy = '0; cmd_reg = '0; cmd_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", mon_rdy, 0);
        chk("rst_rspv", mon_rspv, 0);
        chk("rst_data", mon_rd, 0);
        chk("rst_err", mon_err, 0);
        chk("rst_busy", mon_busy, 0);
        chk("rst_mdc", mon_mdc, 0);
        chk("rst_mdio_o", mon_o, 1);
        chk("rst_mdio_oe", mon_oe, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", mon_rdy, 1);

        // C22 write
        do_frame(1'b0, 2'b01, 5'h01, 5'h00, 16'h1140, 64, {64{1'b1}}, 1'b0, tx, oe, lat, w, rd, er);
        chk("c22wr_tx", tx, 64'hFFFF_FFFF_5082_1140);
        chk("c22wr_oe", oe, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("c22wr_lat", lat, 513);
        chk("c22wr_err", er, 0);
        @(negedge clk);
        chk("c22wr_idle_ready", mon_rdy, 1);
        chk("c22wr_single_pulse", mon_rspv, 0);

        // C22 read, PHY answers 0x0141
        do_frame(1'b0, 2'b10, 5'h1F, 5'h02, 16'h0000, 64, {{46{1'b1}}, 2'b10, 16'h0141},
                 1'b0, tx, oe, lat, w, rd, er);
        chk("c22rd_pre", tx[63:32], 32'hFFFF_FFFF);
        chk("c22rd_hdr", tx[31:18], 14'b01_10_11111_00010);
        chk("c22rd_oe", oe, 64'hFFFF_FFFF_FFFC_0000);
        chk("c22rd_lat", lat, 513);
        chk("c22rd_data", rd, 16'h0141);
        chk("c22rd_err", er, 0);

        // C22 read with no PHY: line floats high
        do_frame(1'b0, 2'b10, 5'h1F, 5'h02, 16'h0000, 64, {64{1'b1}}, 1'b0, tx, oe, lat, w, rd, er);
        chk("nophy_data", rd, 16'hFFFF);
        chk("nophy_err", er, 1);

        // C45 address frame
        do_frame(1'b1, 2'b00, 5'h03, 5'h01, 16'h0007, 64, {64{1'b1}}, 1'b0, tx, oe, lat, w, rd, er);
        chk("c45adr_tx", tx, 64'hFFFF_FFFF_0186_0007);
        chk("c45adr_oe", oe, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("c45adr_lat", lat, 513);
        chk("c45adr_err", er, 0);
        chk("c45adr_data_hold", rd, 16'hFFFF);

        // C45 read, PHY answers 0xABCD
        do_frame(1'b1, 2'b11, 5'h03, 5'h01, 16'h0000, 64, {{46{1'b1}}, 2'b10, 16'hABCD},
                 1'b0, tx, oe, lat, w, rd, er);
        chk("c45rd_hdr", tx[31:18], 14'b00_11_00011_00001);
        chk("c45rd_oe", oe, 64'hFFFF_FFFF_FFFC_0000);
        chk("c45rd_data", rd, 16'hABCD);
        chk("c45rd_err", er, 0);

        // Reset in the middle of a write's DATA field
        @(negedge clk);
        cmd_c45 = 1'b0; cmd_op = 2'b01; cmd_phy = 5'h01; cmd_reg = 5'h00; cmd_data = 16'h1140;
        cmd_valid = 1'b1;
        w = 0;
        while (!mon_rdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (8 * 50) @(negedge clk);
        chk("midrst_busy_before", mon_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", mon_rdy, 0);
        chk("midrst_rspv", mon_rspv, 0);
        chk("midrst_data", mon_rd, 0);
        chk("midrst_err", mon_err, 0);
        chk("midrst_busy", mon_busy, 0);
        chk("midrst_mdc", mon_mdc, 0);
        chk("midrst_mdio_o", mon_o, 1);
        chk("midrst_mdio_oe", mon_oe, 0);
        rst = 1'b0;
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (mon_rspv) cnt++;
        end
        chk("midrst_no_rsp", cnt, 0);
        do_frame(1'b0, 2'b01, 5'h02, 5'h04, 16'hA5A5, 64, {64{1'b1}}, 1'b0, tx, oe, lat, w, rd, er);
        chk("postrst_tx", tx, 64'hFFFF_FFFF_5112_A5A5);
        chk("postrst_lat", lat, 513);

        // Unsupported C45 on the C22-only instance
        sel = 2'd2;
        do_frame(1'b1, 2'b11, 5'h03, 5'h01, 16'h0000, 64, {64{1'b1}}, 1'b0, tx, oe, lat, w, rd, er);
        chk("noc45_lat", lat, 1);
        chk("noc45_err", er, 1);
        chk("noc45_data", rd, 0);
        @(negedge clk);
        chk("noc45_ready", mon_rdy, 1);
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (mon_mdc) cnt++;
        end
        chk("noc45_no_mdc", cnt, 0);

        // No preamble, cmd_valid held across two back-to-back commands
        sel = 2'd1;
        do_frame(1'b0, 2'b01, 5'h01, 5'h00, 16'h1140, 32, {64{1'b1}}, 1'b1, tx, oe, lat, w, rd, er);
        chk("np1_tx", tx[63:32], 32'h5082_1140);
        chk("np1_oe", oe[63:32], 32'hFFFF_FFFF);
        chk("np1_lat", lat, 257);
        do_frame(1'b0, 2'b01, 5'h02, 5'h04, 16'hA5A5, 32, {64{1'b1}}, 1'b0, tx, oe, lat, w, rd, er);
        chk("np2_wait", w, 0);
        chk("np2_tx", tx[63:32], 32'h5112_A5A5);
        chk("np2_lat", lat, 257);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdio_master.md
# mdio_master

Parametrised MDIO management master supporting IEEE 802.3 Clause 22 and Clause 45 frames. It accepts one command at a time over a valid/ready handshake and generates MDC from the system clock by a configurable divider. It serialises the frame, handles turnaround for reads and returns read data with a presence/error flag. It sits between the register-access fabric and the off-chip PHY pad, which provides the tristate buffer.

## Interface
- `CLK_DIV`, default 50: number of clk cycles per MDC half-period; minimum 2.
- `PREAMBLE_LEN`, default 32: number of preamble '1' bits; range 0..32.
- `SUPPORT_C45`, default 1: when 0, Clause 45 commands are rejected.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command request.
- `cmd_ready`  out  1: high only in IDLE and not in reset.
- `cmd_c45`  in  1: 0 selects Clause 22 (ST=01); 1 selects Clause 45 (ST=00).
- `cmd_op`  in  2: raw OP field.
  - C22: 01 = write, 10 = read.
  - C45: 00 = address, 01 = write, 11 = read, 10 = post-read-increment.
- `cmd_phy`  in  5: PHY address (PRTAD).
- `cmd_reg`  in  5: register address (C22) or DEVAD (C45).
- `cmd_data`  in  16: write data or C45 address.
- `rsp_valid`  out  1: one-cycle completion pulse; there is no backpressure.
- `rsp_data`  out  16: read data; holds its value until the next read completes.
- `rsp_err`  out  1: qualified by `rsp_valid`.
- `busy`  out  1: high from the cycle after acceptance through the `rsp_valid` cycle.
- `mdc`  out  1: management clock.
- `mdio_o`  out  1: serial data out.
- `mdio_oe`  out  1: pad output enable.
- `mdio_i`  in  1: pad input, already synchronised externally.

## Operation
- **Reset values:** `cmd_ready` 0 while `rst` is high, `rsp_valid` 0, `rsp_data` 0, `rsp_err` 0, `busy` 0, `mdc` 0, `mdio_o` 1, `mdio_oe` 0.
- **Acceptance:** a command is accepted when `cmd_valid` and `cmd_ready` are both high. All `cmd_*` fields are latched at that cycle; input changes while busy are ignored.
- **Read classification:** read = (C22 and op 10) or (C45 and op in {11, 10}). Everything else is a write-type frame.
- **Frame order:** PREAMBLE (`PREAMBLE_LEN` bits of 1), ST(2), OP(2), PHY(5), REG(5), TA(2), DATA(16), MSB first.
- **Bit window:** each bit lasts 2·`CLK_DIV` cycles.
  - `mdc` is low for the first half and high for the second.
  - `mdio_o` and `mdio_oe` update on the first cycle of the window.
  - `mdio_i` is sampled on the last cycle of the window.
- **Write-type frames:** `mdio_oe`=1 for the whole frame; TA is driven as 1,0.
- **Read frames:**
  - `mdio_oe` drops to 0 at the start of the first TA bit and stays 0 through DATA.
  - The second TA bit is sampled; if it is 1, `rsp_err`=1. Data is still captured.
- **Unsupported C45:** if `cmd_c45`=1 and `SUPPORT_C45`=0, no frame is generated. `rsp_valid` with `rsp_err`=1 follows the cycle after acceptance, and `rsp_data` is unchanged.
- **State machine:** IDLE → PREAMBLE → HDR (14 bits) → TA (2) → DATA (16) → RESP (1 cycle) → IDLE.
  - PREAMBLE is skipped when `PREAMBLE_LEN`=0.
  - A bit counter resets on every state change.
- **Idle outputs:** in IDLE, `mdc`=0, `mdio_oe`=0, `mdio_o`=1.

## Timing
- **Acceptance cycle T:** at T+1 the block is in PREAMBLE (or HDR), `busy`=1 and `mdc`=0.
- **Frame completion:** `rsp_valid` pulses at T+1+(`PREAMBLE_LEN`+32)·2·`CLK_DIV`, with `rsp_data`/`rsp_err` valid in the same cycle.
- **MDC:** MDC periods are exact with no stretching. `mdc` is 0 in the RESP cycle.
- **Return to idle:** IDLE and `cmd_ready`=1 at the cycle after `rsp_valid`. The earliest next acceptance is that cycle.
- **Reset mid-frame:** the frame is aborted on the next clock edge. All outputs take their reset values and no `rsp_valid` is issued.
- **Counter widths:** the divider counter is clog2(`CLK_DIV`) bits and wraps at `CLK_DIV`-1. The bit counter is 5 bits.

## Structure
- **Package `mdio_pkg`:** ST codes (C22=2'b01, C45=2'b00), OP encodings, state enum, and frame field lengths (HDR=14, TA=2, DATA=16).
- **Sub-module `mdio_mdc_gen`:** divider with enable. Produces `mdc`, a `win_start` strobe (first cycle of a window) and a `win_end` strobe (last cycle). It is held in reset while the master is idle.

## Test plan
All scenarios use `CLK_DIV`=4 and `PREAMBLE_LEN`=32 unless stated.
- **C22 write:** phy=0x01, reg=0x00, data=0x1140. Required: 32 ones, then 01 01 00001 00000 10 0001000101000000. `mdio_oe`=1 throughout. `rsp_valid` at T+513 with `rsp_err`=0.
- **C22 read:** phy=0x1F, reg=0x02; the PHY model drives TA bit 2 = 0 and then 0x0141. Required: `mdio_oe`=0 from TA onward, `rsp_data`=0x0141, `rsp_err`=0.
- **C22 read with no PHY:** `mdio_i` held at 1. Required: `rsp_data`=0xFFFF, `rsp_err`=1.
- **C45 address then read:** first an address frame (phy=0x03, devad=0x01, data=0x0007, ST=00, OP=00). Then a read (OP=11) with the PHY returning 0xABCD. Required: `rsp_data`=0xABCD. With `SUPPORT_C45`=0, required: `rsp_err`=1 at T+1 and no `mdc` toggles.
- **Reset mid-DATA of a write:** required: outputs at reset values on the next cycle and no `rsp_valid`. A command issued after reset produces a complete, correct frame.
- **`PREAMBLE_LEN`=0 with `cmd_valid` held for two back-to-back commands:** required: frame starts at ST, `rsp_valid` at T+257, and the second command is accepted the cycle after the first `rsp_valid`.
